// File: rtl/clk_div_prog.sv
// rtl/clk_div_prog.sv - runtime-programmable clock divider and period tick generator
//
// Divides I_clk by a divisor loaded at run time. Divisor changes take effect
// only at period boundaries (or at once while disabled), so O_clk_div never
// glitches. Optional programmable duty is compiled in with CLKDIV_DUTY_EN.
//
// Ports:
//   I_clk       in   1      system clock, rising edge
//   I_rst_n     in   1      synchronous active-low reset
//   I_en        in   1      run enable
//   I_div_load  in   1      load strobe, samples I_div_val (and I_duty_val)
//   I_div_val   in   CNT_W  requested divisor, clamped up to DIV_MIN
//   I_duty_val  in   CNT_W  requested high length (CLKDIV_DUTY_EN only)
//   O_clk_div   out  1      divided waveform, registered
//   O_tick      out  1      one-cycle pulse at period start
//   O_div_ack   out  1      one-cycle pulse when a pending divisor took effect
//   O_div_cur   out  CNT_W  divisor currently in use
module clk_div_prog #(
  parameter int CNT_W       = 21,
  parameter int DIV_DEFAULT = 1000,
  parameter int DIV_MIN     = 2
) (
  input  logic             I_clk,
  input  logic             I_rst_n,
  input  logic             I_en,
  input  logic             I_div_load,
  input  logic [CNT_W-1:0] I_div_val,
`ifdef CLKDIV_DUTY_EN
  input  logic [CNT_W-1:0] I_duty_val,
`endif
  output logic             O_clk_div,
  output logic             O_tick,
  output logic             O_div_ack,
  output logic [CNT_W-1:0] O_div_cur
);

  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEF_DIV  = CNT_W'(DIV_DEFAULT);
  localparam logic [CNT_W-1:0] DEF_HIGH = DEF_DIV - (DEF_DIV >> 1);
  localparam logic [CNT_W-1:0] MIN_DIV  = CNT_W'(DIV_MIN);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] div_cur;
  logic [CNT_W-1:0] high_len;
  logic [CNT_W-1:0] pend_div;
  logic [CNT_W-1:0] pend_high;
  logic             pend_valid;

  logic [CNT_W-1:0] load_div;
  logic [CNT_W-1:0] load_high;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] div_nxt;
  logic [CNT_W-1:0] high_nxt;
  logic             wrap;
  logic             apply;

  always_comb begin
    load_div = (I_div_val < MIN_DIV) ? MIN_DIV : I_div_val;
`ifdef CLKDIV_DUTY_EN
    // High length is clamped against the already-clamped divisor.
    if (I_duty_val == '0)
      load_high = ONE;
    else if (I_duty_val > load_div - ONE)
      load_high = load_div - ONE;
    else
      load_high = I_duty_val;
`else
    // Odd divisors give the extra cycle to the high phase.
    load_high = load_div - (load_div >> 1);
`endif

    wrap = I_en && (cnt == div_cur - ONE);
    // pend_valid is the registered flag, so a load in the wrap cycle itself
    // waits for the following wrap. While disabled there is no period to
    // protect, so a pending value applies at the next edge.
    apply = pend_valid && (wrap || !I_en);

    div_nxt  = apply ? pend_div  : div_cur;
    high_nxt = apply ? pend_high : high_len;
    cnt_nxt  = (!I_en || wrap) ? '0 : cnt + ONE;
  end

  always_ff @(posedge I_clk) begin
    if (!I_rst_n) begin
      cnt        <= '0;
      div_cur    <= DEF_DIV;
      high_len   <= DEF_HIGH;
      pend_div   <= DEF_DIV;
      pend_high  <= DEF_HIGH;
      pend_valid <= 1'b0;
      O_clk_div  <= 1'b0;
      O_tick     <= 1'b0;
      O_div_ack  <= 1'b0;
    end else begin
      cnt      <= cnt_nxt;
      div_cur  <= div_nxt;
      high_len <= high_nxt;

      // A new load wins over clearing: the newest value stays pending.
      if (I_div_load) begin
        pend_div   <= load_div;
        pend_high  <= load_high;
        pend_valid <= 1'b1;
      end else if (apply) begin
        pend_valid <= 1'b0;
      end

      // Outputs are registered from next-state values so they line up with
      // the counter value of the cycle in which they are seen.
      O_clk_div <= I_en && (cnt_nxt >= div_nxt - high_nxt);
      O_tick    <= wrap;
      O_div_ack <= apply;
    end
  end

  assign O_div_cur = div_cur;

endmodule

// File: doc/clk_div_prog.md
# clk_div_prog

Runtime-programmable clock divider and tick generator for the autocar speed/timing path, the parametrised successor of the fixed-ratio dividers. It divides `I_clk` by a divisor loaded at run time, with glitch-free updates at period boundaries. It drives a divided clock-enable waveform (`O_clk_div`) and a one-cycle period tick (`O_tick`) for speed-control and sampling logic. Optional programmable duty is compiled in by macro.

## Interface
- `CNT_W`, 21: counter/divisor width.
- `DIV_DEFAULT`, 1000: divisor after reset (100 MHz → 100 kHz).
- `DIV_MIN`, 2: smallest legal divisor; smaller loads are clamped up.

Ports:
- `I_clk`  in  1  system clock (100 MHz); all logic on rising edge.
- `I_rst_n`  in  1  synchronous, active-low reset.
- `I_en`  in  1  run enable.
- `I_div_load`  in  1  load strobe; samples `I_div_val` (and `I_duty_val`) every cycle it is high.
- `I_div_val`  in  CNT_W  requested divisor D.
- `I_duty_val`  in  CNT_W  requested high length in cycles; port exists only with `CLKDIV_DUTY_EN`.
- `O_clk_div`  out  1  divided waveform, registered.
- `O_tick`  out  1  one-cycle pulse at period start, registered.
- `O_div_ack`  out  1  one-cycle pulse: pending divisor took effect.
- `O_div_cur`  out  CNT_W  divisor currently in use.

## Operation
- Reset (`I_rst_n`=0 at an edge): cnt=0; div_cur=`DIV_DEFAULT`; high_len=`DIV_DEFAULT`-(`DIV_DEFAULT`>>1); pending cleared; `O_clk_div`=0, `O_tick`=0, `O_div_ack`=0. A reset mid-operation discards any pending load and issues no ack.
- Counter: while `I_en`=1, cnt counts 0..div_cur-1 and wraps to 0. The wrap cycle is the cycle with cnt==div_cur-1.
- Waveform: `O_clk_div`=1 exactly in the cycles where cnt ≥ div_cur-high_len, else 0. It is registered from the next counter value, so no combinational path reaches the output.
- `O_tick`=1 exactly in the cycle where cnt==0 following a wrap. It coincides with the `O_clk_div` 1→0 transition.
- Load: `I_div_load`=1 captures max(`I_div_val`,`DIV_MIN`) into the pending register and sets pending_valid. A second load before application overwrites it; last value wins, and only one ack is issued.
- Apply: at a wrap-cycle edge with pending_valid already set, div_cur and high_len take the pending values and pending_valid clears. A load in the wrap cycle itself is applied at the following wrap.
- Ack: `O_div_ack`=1 for one cycle, the first cycle (cnt==0) of the new period.
- Disabled (`I_en`=0): cnt forced to 0; `O_clk_div`=0 and `O_tick`=0 from the next cycle. Pending applies at the next edge regardless of wrap, with ack the cycle after.
- Re-enable: the period restarts from cnt=0 with no tick for the restart cycle.
- Arithmetic: all compares are unsigned CNT_W-bit. The divisor is never 0 or 1 after clamping.

## Timing
- Period = div_cur cycles. Low phase = div_cur-high_len cycles starting at cnt=0; high phase = high_len cycles ending at cnt=div_cur-1.
- Default high_len = D-(D>>1). Odd D gives the extra cycle to the high phase; D=7 gives low 3, high 4.
- Load-to-effect latency: at most the remainder of the current period plus one full period (wrap-cycle load case). The ack is one cycle after apply.
- `O_div_cur` updates in the same cycle as the `O_div_ack` pulse.

## Configuration
- `CLKDIV_DUTY_EN` defined: the `I_duty_val` port exists and is captured with each load. high_len = clamp(`I_duty_val`, 1, D-1), evaluated against the clamped D.
- `CLKDIV_DUTY_EN` undefined: no `I_duty_val` port; high_len is always D-(D>>1), which gives 50% duty for even D.

## Test plan
- Reset then `I_en`=1 → `O_div_cur`=1000; `O_clk_div` low 500 cycles, high 500; `O_tick` every 1000 cycles.
- Load D=7 at cnt=200 → current 1000-cycle period completes; `O_div_ack` at the next cnt=0; then low 3, high 4 repeating.
- Load D=0 → clamped to 2; `O_div_cur`=2; waveform alternates 1 low, 1 high.
- Load D=9 then D=5 within one period → exactly one ack; `O_div_cur`=5; low 2, high 3.
- `I_en`→0 mid-high-phase → `O_clk_div`=0 next cycle. Load D=4 while disabled → ack two cycles after the load. Re-enable → low 2, high 2 from cnt=0.
- With `CLKDIV_DUTY_EN`: D=10, duty=3 → low 7, high 3. Duty=0 → high 1. Duty=12 → high 9.
